// File: rtl/pb_irq_pkg.sv
// Shared constants and types for the KCPSM6 interrupt controller.
package pb_irq_pkg;

  localparam logic [2:0] OFS_PENDING  = 3'd0;
  localparam logic [2:0] OFS_MASK     = 3'd1;
  localparam logic [2:0] OFS_CLEAR    = 3'd2;
  localparam logic [2:0] OFS_EDGE_SEL = 3'd3;
  localparam logic [2:0] OFS_ID       = 3'd4;
  localparam logic [2:0] OFS_EOI      = 3'd5;

  localparam int ID_VALID_BIT = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  // Builds the ID register value: valid flag plus the lowest-index active request.
  function automatic logic [7:0] make_id(input logic [7:0] req);
    logic [7:0] id;
    id = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        id               = 8'h00;
        id[ID_VALID_BIT] = 1'b1;
        id[2:0]          = 3'(i);
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/pb_irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous request line, plus a
// previous-value flop so the controller can detect rising edges.
module pb_irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronize the raw line and remember last cycle's synchronized value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/pb_irq_controller.sv
// Multi-source interrupt controller sequencing the single KCPSM6
// interrupt/interrupt_ack handshake, with a small port-mapped register file.
module pb_irq_controller
  import pb_irq_pkg::*;
#(
  parameter int          NUM_SOURCES = 8,
  parameter logic [7:0]  BASE_PORT   = 8'h10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_in,
  input  logic [7:0]             port_id,
  input  logic [7:0]             out_port,
  input  logic                   write_strobe,
  input  logic                   read_strobe,
  output logic [7:0]             rd_data,
  output logic                   interrupt,
  input  logic                   interrupt_ack
);

  localparam logic [7:0] VALID_MASK = 8'((9'd1 << NUM_SOURCES) - 9'd1);

  logic [7:0] r_pending;
  logic [7:0] r_mask;
  logic [7:0] r_edge_sel;
  logic [7:0] r_rd_data;
  logic       r_interrupt;
  irq_state_t r_state;

  logic [7:0] w_sync;
  logic [7:0] w_rise;
  logic [7:0] w_set;
  logic [7:0] w_clear;
  logic [7:0] w_req;
  logic [2:0] w_ofs;
  logic       w_hit;
  logic       w_wr;
  logic       w_eoi;
  logic       w_unused_read;

  // Reads have no side effects, so the read qualifier is not needed.
  assign w_unused_read = read_strobe;

  for (genvar g = 0; g < 8; g++) begin : g_src
    if (g < NUM_SOURCES) begin : g_on
      pb_irq_sync_edge u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (irq_in[g]),
        .o_sync  (w_sync[g]),
        .o_rise  (w_rise[g])
      );
    end else begin : g_off
      assign w_sync[g] = 1'b0;
      assign w_rise[g] = 1'b0;
    end
  end

  assign w_hit   = (port_id[7:3] == BASE_PORT[7:3]);
  assign w_ofs   = port_id[2:0];
  assign w_wr    = write_strobe & w_hit;
  assign w_clear = (w_wr && (w_ofs == OFS_CLEAR)) ? (out_port & VALID_MASK) : 8'h00;
  assign w_eoi   = w_wr && (w_ofs == OFS_EOI);
  assign w_set   = (r_edge_sel & w_rise) | (~r_edge_sel & w_sync);
  assign w_req   = r_pending & r_mask;

  // Pending capture (set beats clear) and the firmware-writable mask/edge registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending  <= 8'h00;
      r_mask     <= 8'h00;
      r_edge_sel <= 8'h00;
    end else begin
      r_pending <= ((r_pending & ~w_clear) | w_set) & VALID_MASK;
      if (w_wr && (w_ofs == OFS_MASK)) begin
        r_mask <= out_port & VALID_MASK;
      end
      if (w_wr && (w_ofs == OFS_EDGE_SEL)) begin
        r_edge_sel <= out_port & VALID_MASK;
      end
    end
  end

  // Registered read mux, refreshed from port_id every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= 8'h00;
    end else if (!w_hit) begin
      r_rd_data <= 8'h00;
    end else begin
      case (w_ofs)
        OFS_PENDING:  r_rd_data <= r_pending;
        OFS_MASK:     r_rd_data <= r_mask;
        OFS_EDGE_SEL: r_rd_data <= r_edge_sel;
        OFS_ID:       r_rd_data <= make_id(w_req);
        default:      r_rd_data <= 8'h00;
      endcase
    end
  end

  // Handshake sequencer: one outstanding interrupt, re-armed only by EOI.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_interrupt <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req != 8'h00) begin
            r_state     <= ASSERT;
            r_interrupt <= 1'b1;
          end else begin
            r_interrupt <= 1'b0;
          end
        end
        ASSERT: begin
          if (interrupt_ack) begin
            r_state     <= SERVICE;
            r_interrupt <= 1'b0;
          end else begin
            r_interrupt <= 1'b1;
          end
        end
        SERVICE: begin
          r_interrupt <= 1'b0;
          if (w_eoi) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_interrupt <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data   = r_rd_data;
  assign interrupt = r_interrupt;

endmodule

// File: doc/pb_irq_controller.md
Name: pb_irq_controller

Overview:
- Multi-source interrupt controller that sequences the single KCPSM6 interrupt/interrupt_ack handshake for up to 8 peripheral requesters.
- Sits on the KCPSM6 port bus beside the UART peripherals; firmware reads pending/ID and writes mask/clear/EOI through port I/O.
- Guarantees one outstanding interrupt at a time. Interrupt is held until acknowledged, then re-armed only after firmware EOI.

Parameters:
- NUM_SOURCES, 8, number of irq_in lines (1..8); register bits at and above NUM_SOURCES read 0, ignore writes.
- BASE_PORT, 8'h10, port_id of register offset 0; offsets 0..5 decoded, BASE_PORT must be 8-aligned.

Ports:
- clk  in  1  system clock, shared with the KCPSM6.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  NUM_SOURCES  asynchronous peripheral requests.
- port_id  in  8  KCPSM6 port address.
- out_port  in  8  KCPSM6 write data.
- write_strobe  in  1  KCPSM6 write qualifier.
- read_strobe  in  1  KCPSM6 read qualifier (no read side effects; informational only).
- rd_data  out  8  read data, OR-ed or muxed into KCPSM6 in_port by the top level.
- interrupt  out  1  to KCPSM6 interrupt.
- interrupt_ack  in  1  from KCPSM6 interrupt_ack.

Behaviour:
- Reset (synchronous, active-high): pending=0, mask=0 (all disabled), edge_sel=0 (level), sync flops=0, interrupt=0, rd_data=0, FSM=IDLE.
- Register map (offset from BASE_PORT):
  - 0 PENDING (RO)
  - 1 MASK (RW, 1=enabled)
  - 2 CLEAR (WO, write-1-to-clear pending)
  - 3 EDGE_SEL (RW, 1=rising edge, 0=level)
  - 4 ID (RO, bit7=valid, bits2:0=lowest-index pending&mask; 8'h00 when none)
  - 5 EOI (WO, any value)
- Writes take effect on the clk edge where write_strobe=1 and port_id matches. Unmapped writes are ignored.
- rd_data is registered from port_id every cycle (1-cycle latency, valid for the KCPSM6 2-cycle port window). Unmapped or write-only offsets read 8'h00.
- Input path: each irq_in goes through a 2-flop synchronizer. Edge mode sets pending on sync rising edge (sync=1, prev=0). Level mode sets pending on every cycle sync=1.
- Same-cycle set and CLEAR on one bit: set wins. In level mode a cleared bit re-sets next cycle while the line is still high.
- Mask gates only the request, never the pending capture. Masked sources still latch pending.
- FSM:
  - IDLE: interrupt=0. Moves to ASSERT on the cycle after any (pending & mask) != 0.
  - ASSERT: interrupt=1, held regardless of pending/mask changes. interrupt_ack=1 -> SERVICE, with interrupt=0 the following cycle.
  - SERVICE: interrupt=0. EOI write -> IDLE. If pending&mask is still nonzero, re-asserts 1 cycle after entering IDLE.
- Latency: synchronized edge to pending = 1 cycle; pending to interrupt=1 = 1 cycle. irq_in pin to interrupt is at most 4 clk.
- EOI in IDLE or ASSERT: ignored. interrupt_ack outside ASSERT: ignored.
- Reset mid-ASSERT or mid-SERVICE returns to IDLE with interrupt=0 next cycle and clears all state.
- ID priority: lowest index wins. ID is computed combinationally from current pending&mask at read time, not latched at assert.

Decomposition:
- Package pb_irq_pkg holds:
  - register offset constants (OFS_PENDING=0 .. OFS_EOI=5)
  - FSM state encoding (IDLE, ASSERT, SERVICE)
  - ID valid-bit position
- Sub-module pb_irq_sync_edge: per-source 2-flop synchronizer plus previous-value flop. Outputs sync level and rise pulse; instantiated NUM_SOURCES times via generate.

Test Plan:
- Reset, then read offsets 0..5 -> all 8'h00; interrupt=0.
- MASK=8'h01, EDGE_SEL=8'h01, pulse irq_in[0] for 1 cycle -> PENDING=8'h01, interrupt=1 within 4 cycles, held 20 cycles until interrupt_ack; ID=8'h80; CLEAR 8'h01 + EOI -> interrupt stays 0.
- MASK=8'hFF, level sources 3 and 5 high -> ID=8'h83; CLEAR 8'h08 while irq_in[3] high -> PENDING still 8'h28 next cycle; drop irq_in[3], CLEAR 8'h08 -> PENDING=8'h20, ID=8'h85.
- MASK=8'h00, edge on source 2 -> PENDING=8'h04, interrupt stays 0; write MASK=8'h04 -> interrupt=1 two cycles later.
- In SERVICE with pending&mask nonzero, write EOI -> interrupt re-asserts exactly 2 cycles after the EOI write edge; EOI written in IDLE -> no state change.
- Edge source 1 pulses in the same cycle as CLEAR 8'h02 write -> PENDING bit1=1; reset asserted during ASSERT -> interrupt=0, MASK=8'h00 next cycle.
